fb_fill_engine: RTL and testbench
=================================

FB_FILL_ENGINE -- requirements
Module: fb_fill_engine

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL set the framebuffer word-address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the framebuffer word width.
REQ-003 Port clk, input, 1: SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: SHALL be the asynchronous, active-high reset.
REQ-005 Port start, input, 1: SHALL request a fill; sampled only in IDLE.
REQ-006 Port base_addr, input, ADDR_W: SHALL give the first word address of the rectangle.
REQ-007 Port width, input, 8: SHALL give words per row.
REQ-008 Port height, input, 8: SHALL give the row count.
REQ-009 Port stride, input, ADDR_W: SHALL give the address increment between row starts.
REQ-010 Port fill_value, input, DATA_W: SHALL give the word written.
REQ-011 Port mem_gnt, input, 1: SHALL indicate the memory write port is available this cycle.
REQ-012 Port mem_addr, output, ADDR_W: SHALL give the current write address.
REQ-013 Port mem_data, output, DATA_W: SHALL give the current write data.
REQ-014 Port mem_w, output, 1: SHALL be the write strobe; one word is written per cycle when high.
REQ-015 Port busy, output, 1: SHALL be high while in FILL.
REQ-016 Port done, output, 1: SHALL pulse high for exactly one cycle at fill completion.

Function
REQ-017 FSM states SHALL be IDLE, FILL, DONE.
REQ-018 In IDLE, start=1 SHALL latch all inputs and move to FILL next cycle; if width=0 or height=0 it SHALL move to DONE instead and issue no write.
REQ-019 The block SHALL not re-sample inputs while in FILL or DONE.
REQ-020 In FILL, mem_w SHALL equal mem_gnt combinationally; mem_addr and mem_data SHALL be registered and stable while mem_gnt is low.
REQ-021 The first write SHALL be presented on the first cycle after start is accepted.
REQ-022 Each granted write SHALL advance a column counter; the address SHALL increment by 1 within a row.
REQ-023 After the last column, the next address SHALL be row_start+stride, and the row counter SHALL increment.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_W, so it wraps silently at 0x7FFF to 0x0000.
REQ-025 The granted write of column width-1 of row height-1 SHALL move FILL to DONE.
REQ-026 DONE SHALL last one cycle with done=1 and then return to IDLE; start in DONE SHALL be ignored.
REQ-027 The total number of writes SHALL equal width*height exactly; stalls SHALL neither drop nor duplicate writes.

Reset
REQ-028 reset SHALL force IDLE immediately, including mid-fill, which aborts the fill with no done pulse.
REQ-029 Under reset, mem_w, busy and done SHALL be 0, and mem_addr, mem_data and all counters SHALL be 0.

Configuration
REQ-030 With FB_FILL_PATTERN_EN defined, mem_data SHALL alternate fill_value/~fill_value per column, and the phase SHALL invert on each new row to form a checkerboard.
REQ-031 Without FB_FILL_PATTERN_EN, every write SHALL carry fill_value.

Structure
REQ-032 A shared package SHALL hold the ADDR_W and DATA_W defaults and the FSM state enumeration.
REQ-033 One sub-module, fb_fill_addr_gen, SHALL hold the row, column and address counters; the FSM and data path SHALL remain in fb_fill_engine.

Verification
REQ-034 Test: base=0x0100, width=4, height=2, stride=0x00A0, gnt=1 -> writes at 0x0100..0x0103 and 0x01A0..0x01A3; done is high on the 9th cycle after start.
REQ-035 Test: same fill with mem_gnt toggled 1,0,1,0 -> exactly 8 writes at the same addresses; mem_addr is held during gnt=0.
REQ-036 Test: width=0, height=5 -> no mem_w; done pulses on the cycle after start; busy stays 0.
REQ-037 Test: base=0x7FFE, width=4, height=1 -> writes at 0x7FFE, 0x7FFF, 0x0000, 0x0001.
REQ-038 Test: reset asserted after 3 writes of a 4x4 fill -> mem_w, busy and done drop to 0 at once; no done pulse; a new start then behaves normally.
REQ-039 Test: with FB_FILL_PATTERN_EN, fill_value=0x00FF, width=2, height=2 -> data is 0x00FF, 0xFF00, 0xFF00, 0x00FF.

Source files
------------

// File: rtl/fb_fill_pkg.sv
// Shared defaults and FSM state encoding for the framebuffer rectangle fill engine.
package fb_fill_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/fb_fill_addr_gen.sv
// Row/column/address counters for the rectangle fill; geometry is latched on load
// and the address steps by 1 within a row and by stride between row starts.
module fb_fill_addr_gen
    import fb_fill_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [7:0]        width,
    input  logic [7:0]        height,
    output logic [ADDR_W-1:0] addr,
    output logic              row_lsb,
    output logic              col_last,
    output logic              fill_last
);

    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] row_start_reg;
    logic [ADDR_W-1:0] stride_reg;
    logic [7:0]        col_reg;
    logic [7:0]        row_reg;
    logic [7:0]        width_reg;
    logic [7:0]        height_reg;
    logic [ADDR_W-1:0] next_row_start;

    assign next_row_start = row_start_reg + stride_reg;
    assign col_last       = (col_reg == width_reg - 8'd1);
    assign fill_last      = col_last && (row_reg == height_reg - 8'd1);
    assign addr           = addr_reg;
    assign row_lsb        = row_reg[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg      <= '0;
            row_start_reg <= '0;
            stride_reg    <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
            width_reg     <= '0;
            height_reg    <= '0;
        end else if (load) begin
            addr_reg      <= base_addr;
            row_start_reg <= base_addr;
            stride_reg    <= stride;
            col_reg       <= '0;
            row_reg       <= '0;
            width_reg     <= width;
            height_reg    <= height;
        end else if (advance) begin
            // Sums are ADDR_W wide, so wrap past the top of memory is free.
            if (col_last) begin
                col_reg       <= '0;
                row_reg       <= row_reg + 8'd1;
                row_start_reg <= next_row_start;
                addr_reg      <= next_row_start;
            end else begin
                col_reg  <= col_reg + 8'd1;
                addr_reg <= addr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/fb_fill_engine.sv
// Rectangle fill engine: writes fill_value over a width x height block, one word per granted cycle.
// Define FB_FILL_PATTERN_EN to write a checkerboard of fill_value / ~fill_value instead.
module fb_fill_engine
    import fb_fill_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        width,
    input  logic [7:0]        height,
    input  logic [ADDR_W-1:0] stride,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_w,
    output logic              busy,
    output logic              done
);

`ifdef FB_FILL_PATTERN_EN
    localparam logic PATTERN_EN = 1'b1;
`else
    localparam logic PATTERN_EN = 1'b0;
`endif

    fill_state_t       state_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [DATA_W-1:0] fill_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] data_next;
    logic              start_ok;
    logic              zero_dim;
    logic              advance;
    logic              row_lsb;
    logic              col_last;
    logic              fill_last;

    assign start_ok = (state_reg == ST_IDLE) && start;
    assign zero_dim = (width == 8'd0) || (height == 8'd0);
    assign advance  = (state_reg == ST_FILL) && mem_gnt;

    // A new row starts with the phase of its row index; inside a row the phase flips per word.
    always_comb begin
        data_next = data_reg ^ {DATA_W{PATTERN_EN}};
        if (col_last) begin
            data_next = fill_reg ^ {DATA_W{PATTERN_EN & ~row_lsb}};
        end
    end

    fb_fill_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (start_ok),
        .advance   (advance),
        .base_addr (base_addr),
        .stride    (stride),
        .width     (width),
        .height    (height),
        .addr      (mem_addr),
        .row_lsb   (row_lsb),
        .col_last  (col_last),
        .fill_last (fill_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            fill_reg  <= '0;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        fill_reg <= fill_value;
                        data_reg <= fill_value;
                        if (zero_dim) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_FILL;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (advance) begin
                        if (fill_last) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            data_reg <= data_next;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_w    = busy_reg & mem_gnt;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign mem_data = data_reg;

endmodule

// File: tb/tb_fb_fill_engine.sv
// Self-checking bench for fb_fill_engine against a row/column reference model of the fill.
module tb_fb_fill_engine;

    localparam int AW = 15;
    localparam int DW = 16;
`ifdef FB_FILL_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    width = '0;
    logic [7:0]    height = '0;
    logic [AW-1:0] stride = '0;
    logic [DW-1:0] fill_value = '0;
    logic          mem_gnt = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_w;
    logic          busy;
    logic          done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fb_fill_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .width      (width),
        .height     (height),
        .stride     (stride),
        .fill_value (fill_value),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_w      (mem_w),
        .busy       (busy),
        .done       (done)
    );

    // Runs one fill and checks every write, stall hold, busy, done timing and DONE-state start.
    // gmode: 0 = grant always, 1 = grant 1,0,1,0..., 2 = random grant.
    task automatic do_fill(input logic [AW-1:0] b, input logic [7:0] w, input logic [7:0] h,
                           input logic [AW-1:0] s, input logic [DW-1:0] f, input int gmode,
                           input string tag);
        logic [AW-1:0] exp_a[$];
        logic [DW-1:0] exp_d[$];
        logic [31:0]   lin;
        int            idx, last_wr, done_cyc, n;
        bit            ph;
        for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++) begin
                lin = 32'(b) + 32'(r) * 32'(s) + 32'(c);
                ph  = PAT_EN && (((r + c) % 2) == 1);
                exp_a.push_back(lin[AW-1:0]);
                exp_d.push_back(ph ? ~f : f);
            end
        end
        n = exp_a.size();
        @(negedge clk);
        start = 1'b1; base_addr = b; width = w; height = h; stride = s; fill_value = f;
        mem_gnt = 1'b0;
        @(negedge clk);
        start = 1'b0;
        base_addr = AW'($urandom); width = 8'($urandom); height = 8'($urandom);
        stride = AW'($urandom); fill_value = DW'($urandom);
        idx = 0; last_wr = 0; done_cyc = 0;
        for (int cyc = 1; cyc <= 3000 && done_cyc == 0; cyc++) begin
            if (cyc > 1) @(negedge clk);
            case (gmode)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = (cyc % 2) == 1;
                default: mem_gnt = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            if (done === 1'b1) begin
                done_cyc = cyc;
                total++;
                if (mem_w !== 1'b0 || busy !== 1'b0) begin
                    $display("FAIL %s done_cycle_outputs: mem_w=%b busy=%b required 0/0", tag, mem_w, busy);
                end else passed++;
                start = 1'b1;
            end else begin
                total++;
                if (busy !== (n > 0)) begin
                    $display("FAIL %s busy cyc=%0d: got %b required %b", tag, cyc, busy, n > 0);
                end else passed++;
                total++;
                if (mem_w !== (busy & mem_gnt)) begin
                    $display("FAIL %s mem_w cyc=%0d: got %b required %b", tag, cyc, mem_w, busy & mem_gnt);
                end else passed++;
                if (mem_w === 1'b1) begin
                    total++;
                    if (idx >= n) begin
                        $display("FAIL %s extra_write addr=%h required no write", tag, mem_addr);
                    end else if (mem_addr !== exp_a[idx] || mem_data !== exp_d[idx]) begin
                        $display("FAIL %s write%0d: addr=%h data=%h required addr=%h data=%h",
                                 tag, idx, mem_addr, mem_data, exp_a[idx], exp_d[idx]);
                    end else passed++;
                    idx++;
                    last_wr = cyc;
                end else if (busy === 1'b1 && idx < n) begin
                    total++;
                    if (mem_addr !== exp_a[idx] || mem_data !== exp_d[idx]) begin
                        $display("FAIL %s stall_hold cyc=%0d: addr=%h data=%h required addr=%h data=%h",
                                 tag, cyc, mem_addr, mem_data, exp_a[idx], exp_d[idx]);
                    end else passed++;
                end
            end
        end
        total++;
        if (done_cyc == 0) begin
            $display("FAIL %s timeout: no done within 3000 cycles, writes=%0d required %0d", tag, idx, n);
        end else passed++;
        total++;
        if (idx != n) begin
            $display("FAIL %s write_count: got %0d required %0d", tag, idx, n);
        end else passed++;
        total++;
        if (done_cyc != ((n == 0) ? 1 : last_wr + 1)) begin
            $display("FAIL %s done_cycle: got %0d required %0d", tag, done_cyc, (n == 0) ? 1 : last_wr + 1);
        end else passed++;
        if (gmode == 0) begin
            total++;
            if (done_cyc != n + 1) begin
                $display("FAIL %s done_latency: got %0d required %0d", tag, done_cyc, n + 1);
            end else passed++;
        end
        // start was high during the DONE cycle; it must not have been accepted.
        @(negedge clk);
        start = 1'b0;
        mem_gnt = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL %s after_done: busy=%b done=%b required 0/0", tag, busy, done);
        end else passed++;
        $display("%s: base=%h w=%0d h=%0d stride=%h fill=%h gmode=%0d writes=%0d done_cycle=%0d",
                 tag, b, w, h, s, f, gmode, idx, done_cyc);
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (mem_w !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== '0 || mem_data !== '0) begin
            $display("FAIL reset_state: mem_w=%b busy=%b done=%b addr=%h data=%h required all 0",
                     mem_w, busy, done, mem_addr, mem_data);
        end else passed++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("reset: outputs checked at zero");
    endtask

    task automatic test_basic();
        do_fill(15'h0100, 8'd4, 8'd2, 15'h00A0, 16'h1234, 0, "basic");
    endtask

    task automatic test_stall();
        do_fill(15'h0100, 8'd4, 8'd2, 15'h00A0, 16'h1234, 1, "stall");
    endtask

    task automatic test_zero_dim();
        do_fill(15'h0040, 8'd0, 8'd5, 15'h0010, 16'hBEEF, 0, "zero_w");
        do_fill(15'h0040, 8'd3, 8'd0, 15'h0010, 16'hBEEF, 0, "zero_h");
    endtask

    task automatic test_wrap();
        do_fill(15'h7FFE, 8'd4, 8'd1, 15'h0123, 16'hA5A5, 0, "wrap_col");
        do_fill(15'h7FF0, 8'd2, 8'd3, 15'h0008, 16'h5A5A, 2, "wrap_row");
    endtask

    task automatic test_pattern();
        do_fill(15'h0300, 8'd2, 8'd2, 15'h0020, 16'h00FF, 0, "pattern");
    endtask

    task automatic test_abort();
        int wr = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 15'h0200; width = 8'd4; height = 8'd4;
        stride = 15'h0010; fill_value = 16'hC3C3;
        @(negedge clk);
        start = 1'b0;
        mem_gnt = 1'b1;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            if (cyc > 1) @(negedge clk);
            #1;
            if (mem_w === 1'b1) wr++;
        end
        total++;
        if (wr != 3) begin
            $display("FAIL abort_pre_writes: got %0d required 3", wr);
        end else passed++;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (mem_w !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== '0 || mem_data !== '0) begin
            $display("FAIL abort_reset: mem_w=%b busy=%b done=%b addr=%h data=%h required all 0",
                     mem_w, busy, done, mem_addr, mem_data);
        end else passed++;
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            #1;
            total++;
            if (done !== 1'b0 || mem_w !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL abort_quiet cyc=%0d: done=%b mem_w=%b busy=%b required 0", cyc, done, mem_w, busy);
            end else passed++;
        end
        mem_gnt = 1'b0;
        $display("abort: writes_before_reset=%0d", wr);
        do_fill(15'h0200, 8'd4, 8'd4, 15'h0010, 16'hC3C3, 0, "after_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            do_fill(AW'($urandom), 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
                    AW'($urandom), DW'($urandom), 2, "random");
        end
    endtask

    task automatic test_back_to_back();
        do_fill(15'h1000, 8'd3, 8'd3, 15'h0040, 16'h0F0F, 0, "b2b_a");
        do_fill(15'h2000, 8'd5, 8'd2, 15'h0100, 16'hF00F, 1, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_dim();
        test_wrap();
        test_pattern();
        test_abort();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
